// File: rtl/fadd_arb_pkg.sv
// fadd_arb_pkg: shared FPU constants, pipeline stage types and a leading-zero helper
// used by the two-requester adder arbiter and its single-precision adder.
package fadd_arb_pkg;
    localparam int NUM_REQ = 2;
    localparam int FW = 32;
    localparam logic [FW-1:0] QNAN = 32'hFFC00000;
    localparam logic [FW-1:0] QBIT = 32'h00400000;

    typedef struct packed {
        logic [FW-1:0] x1;
        logic [FW-1:0] x2;
        logic          id;
    } op_t;

    typedef struct packed {
        logic [FW-1:0] y;
        logic          ovf;
        logic          id;
    } res_t;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction
endpackage

// File: rtl/fadd_arb_fadd.sv
// fadd: combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with gradual underflow and an overflow flag for finite operands that round to infinity.
module fadd
    import fadd_arb_pkg::*;
(
    input  logic [FW-1:0] x1,
    input  logic [FW-1:0] x2,
    output logic [FW-1:0] y,
    output logic          ovf
);
    logic          swap, nan1, nan2, inf1, inf2, zs, big;
    logic [FW-1:0] l, s;
    logic [7:0]    el, es;
    logic [23:0]   ml, ms;
    logic [8:0]    d, sh, re;
    logic [26:0]   ext, mask, al, n;
    logic [27:0]   sum;
    logic [4:0]    lz;
    logic [24:0]   m;
    logic [9:0]    ef;
    always_comb begin
        swap = x2[30:0] > x1[30:0];
        l = swap ? x2 : x1;
        s = swap ? x1 : x2;
        el = (l[30:23] == 8'd0) ? 8'd1 : l[30:23];
        es = (s[30:23] == 8'd0) ? 8'd1 : s[30:23];
        ml = {l[30:23] != 8'd0, l[22:0]};
        ms = {s[30:23] != 8'd0, s[22:0]};
        d = {1'b0, el} - {1'b0, es};
        ext = {ms, 3'b000};
        mask = (27'd1 << d) - 27'd1;
        // bits shifted past the guard position collapse into the sticky bit
        al = (d > 9'd26) ? {26'd0, |ms} : ((ext >> d) | {26'd0, |(ext & mask)});
        sum = (l[31] == s[31]) ? {1'b0, ml, 3'b000} + {1'b0, al} : {1'b0, ml, 3'b000} - {1'b0, al};
        lz = lzc27(sum[26:0]);
        sh = ({4'd0, lz} > {1'b0, el} - 9'd1) ? {1'b0, el} - 9'd1 : {4'd0, lz};
        n = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << sh;
        re = sum[27] ? {1'b0, el} + 9'd1 : {1'b0, el} - sh;
        m = {1'b0, n[26:3]} + 25'(n[2] & (n[1] | n[0] | n[3]));
        ef = m[24] ? {1'b0, re} + 10'd1 : (m[23] ? {1'b0, re} : 10'd0);
        nan1 = (&x1[30:23]) & (|x1[22:0]);
        nan2 = (&x2[30:23]) & (|x2[22:0]);
        inf1 = (&x1[30:23]) & ~(|x1[22:0]);
        inf2 = (&x2[30:23]) & ~(|x2[22:0]);
        zs = sum == 28'd0;
        big = ef >= 10'd255;
        y = nan1 ? (x1 | QBIT) :
            nan2 ? (x2 | QBIT) :
            (inf1 & inf2 & (x1[31] ^ x2[31])) ? QNAN :
            inf1 ? x1 :
            inf2 ? x2 :
            zs ? {x1[31] & x2[31], 31'd0} :
            big ? {l[31], 8'hFF, 23'd0} :
            {l[31], ef[7:0], m[24] ? 23'd0 : m[22:0]};
        ovf = !(nan1 | nan2 | inf1 | inf2 | zs) & big;
    end
endmodule

// File: rtl/fadd_arb.sv
// fadd_arb: round-robin arbiter sharing one fadd between two requesters through
// a two-stage (operand / result) pipeline with ready/valid handshakes on both sides.
module fadd_arb
    import fadd_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  logic [FW-1:0]       x1_0,
    input  logic [FW-1:0]       x2_0,
    input  logic [FW-1:0]       x1_1,
    input  logic [FW-1:0]       x2_1,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [FW-1:0]       resp_y,
    output logic                resp_ovf,
    output logic                busy
);
    logic          s1_v, s2_v, prio, adv1, adv2, gnt_v, gnt_id, rsp_xfer, fovf;
    logic [FW-1:0] fy;
    logic [1:0]    cnt;
    op_t           s1;
    res_t          s2;
    always_comb begin
        adv2 = !s2_v || resp_ready;
        adv1 = !s1_v || adv2;
        gnt_v = adv1 && !rst && |req_valid;
        gnt_id = &req_valid ? prio : req_valid[1];
        req_ready = gnt_v ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        rsp_xfer = s2_v && resp_ready;
    end
    fadd u_fadd (
        .x1  (s1.x1),
        .x2  (s1.x2),
        .y   (fy),
        .ovf (fovf)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1   <= '0;
            s2   <= '0;
            prio <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (adv1) s1_v <= gnt_v;
            if (gnt_v) begin
                s1   <= '{x1: gnt_id ? x1_1 : x1_0, x2: gnt_id ? x2_1 : x2_0, id: gnt_id};
                prio <= ~gnt_id;
            end
            if (adv2) begin
                s2_v <= s1_v;
                s2   <= '{y: fy, ovf: fovf, id: s1.id};
            end
            cnt <= cnt + 2'(gnt_v) - 2'(rsp_xfer);
        end
    end
    assign resp_valid = s2_v;
    assign resp_y     = s2.y;
    assign resp_ovf   = s2.ovf;
    assign resp_id    = s2.id;
    assign busy       = cnt != 2'd0;
endmodule

// File: tb/tb_fadd_arb.sv
// tb_fadd_arb: directed vectors against a queue-based model of the arbiter
// (round-robin grant, capacity two, two-cycle latency, in-order results).
module tb_fadd_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] x1_0 = '0, x2_0 = '0, x1_1 = '0, x2_1 = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_id, resp_ovf, busy;
    logic [31:0] resp_y;

    fadd_arb dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .x1_0(x1_0), .x2_0(x2_0), .x1_1(x1_1), .x2_1(x2_1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_y(resp_y), .resp_ovf(resp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam int NV = 13;
    logic [31:0] ta [NV] = '{32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h40400000,
                             32'h00000001, 32'h80000000, 32'h3FC00000, 32'h40A00000, 32'h7FC00000,
                             32'h3F800000, 32'h3F800001, 32'h00800000};
    logic [31:0] tb_ [NV] = '{32'h40000000, 32'h7F7FFFFF, 32'hFF800000, 32'hBF800000, 32'h3F800000,
                              32'h00000001, 32'h80000000, 32'h3FC00000, 32'hC0400000, 32'h3F800000,
                              32'h33800000, 32'h33800000, 32'h80000001};
    logic [31:0] ty [NV] = '{32'h40400000, 32'h7F800000, 32'hFFC00000, 32'h00000000, 32'h40800000,
                             32'h00000002, 32'h80000000, 32'h40400000, 32'h40000000, 32'h7FC00000,
                             32'h3F800000, 32'h3F800002, 32'h007FFFFF};
    logic        to [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    typedef struct {
        logic        id;
        logic [31:0] y;
        logic        o;
        int          age;
    } ent_t;
    ent_t q[$];
    int   vi [2] = '{0, 3};
    logic mprio = 1'b0;
    int   ncmp = 0, nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // operand driver follows the model's per-requester vector pointer
    always @(posedge clk) begin
        #1;
        x1_0 = ta[vi[0]]; x2_0 = tb_[vi[0]];
        x1_1 = ta[vi[1]]; x2_1 = tb_[vi[1]];
    end

    always @(negedge clk) begin
        logic erv, can, g, gid;
        logic [1:0] err;
        ent_t e;
        if (rst) begin
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_y", resp_y, 0);
            chk("rst_resp_ovf", resp_ovf, 0);
            chk("rst_resp_id", resp_id, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            q.delete();
            mprio = 1'b0;
        end else begin
            erv = 1'b0;
            if (q.size() > 0) erv = q[0].age >= 1;
            chk("resp_valid", resp_valid, erv);
            if (erv) begin
                chk("resp_id", resp_id, q[0].id);
                chk("resp_y", resp_y, q[0].y);
                chk("resp_ovf", resp_ovf, q[0].o);
            end
            can = q.size() < 2 || resp_ready;
            g = can && req_valid != 2'b00;
            gid = (req_valid == 2'b11) ? mprio : req_valid[1];
            err = g ? (gid ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", req_ready, err);
            chk("busy", busy, q.size() != 0);
            if (erv && resp_ready) void'(q.pop_front());
            foreach (q[k]) q[k].age = q[k].age + 1;
            if (g) begin
                e.id = gid;
                e.y = ty[vi[gid]];
                e.o = to[vi[gid]];
                e.age = 0;
                q.push_back(e);
                vi[gid] = (vi[gid] + 1) % NV;
                mprio = ~gid;
            end
        end
    end

    task automatic issue_one(input logic [31:0] ey, input logic eo);
        req_valid = 2'b01;
        @(posedge clk); #1 req_valid = 2'b00;
        @(posedge clk); #1;
        chk("lit_single_valid", resp_valid, 1);
        chk("lit_single_y", resp_y, ey);
        chk("lit_single_ovf", resp_ovf, eo);
        chk("lit_single_id", resp_id, 0);
        chk("lit_single_busy", busy, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        issue_one(32'h40400000, 1'b0);
        issue_one(32'h7F800000, 1'b1);
        issue_one(32'hFFC00000, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1 chk("lit_tie_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("lit_bp_ready", req_ready, 0);
            chk("lit_bp_busy", busy, 1);
            chk("lit_bp_valid", resp_valid, 1);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1; req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1 chk("lit_drain_busy", busy, 0);
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("lit_midrst_valid", resp_valid, 0);
        chk("lit_midrst_busy", busy, 0);
        chk("lit_midrst_ready", req_ready, 0);
        @(posedge clk); #1 rst = 1'b0; req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_post_rst_valid", resp_valid, 0);
        chk("lit_post_rst_busy", busy, 0);
        for (int k = 0; k < 40; k++) begin
            req_valid = 2'((k * 5 + k / 3) % 4);
            resp_ready = (k % 3) != 1;
            @(posedge clk); #1;
        end
        req_valid = 2'b00; resp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("lit_final_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
